// File: rtl/run_detector_p.sv
// run_detector_p: counts runs of consecutive ones on a serial input.
// Provides a Mealy detect (same-cycle) and a Moore detect (one cycle later),
// each with its own saturating-or-wrapping event counter.
module run_detector_p #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1,
  parameter int SAT     = 1,
  localparam int SW     = $clog2(RUN_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             w,
  output logic             z_me,
  output logic             z_mo,
  output logic [CNT_W-1:0] count_me,
  output logic [CNT_W-1:0] count_mo,
  output logic [SW-1:0]    state
);

  localparam logic [SW-1:0] RUN_S  = SW'(RUN_LEN);
  localparam logic [SW-1:0] LAST_S = SW'(RUN_LEN - 1);
  localparam logic [SW-1:0] ONE_S  = SW'(1);
  localparam logic          OVL_B  = (OVERLAP != 0);
  localparam logic          SAT_B  = (SAT != 0);

  logic [SW-1:0] state_q, state_d;
  logic          z_me_int, z_mo_int;

  // Counter 0 tracks Mealy detections, counter 1 tracks Moore detection cycles.
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       inc;

  // State register: run length so far, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: count ones, drop to zero on a zero, hold when not enabled.
  always_comb begin
    state_d = state_q;
    if (en) begin
      if (!w) begin
        state_d = '0;
      end else if (state_q != RUN_S) begin
        state_d = state_q + ONE_S;
      end else begin
        // Disjoint mode restarts the block with this one as its first member.
        state_d = OVL_B ? RUN_S : ONE_S;
      end
    end
  end

  // Outputs: Mealy looks at the incoming bit, Moore only at the state.
  always_comb begin
    z_mo_int = (state_q == RUN_S);
    z_me_int = en & w & ((state_q == LAST_S) | (OVL_B & (state_q == RUN_S)));
  end

  assign inc[0] = z_me_int;
  assign inc[1] = en & (state_q == RUN_S);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      // Counter next value: clear wins, then increment with saturate or wrap.
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (clr) begin
          cnt_d[gi] = '0;
        end else if (inc[gi]) begin
          if (SAT_B && (&cnt_q[gi])) begin
            cnt_d[gi] = cnt_q[gi];
          end else begin
            cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
          end
        end
      end

      // Counter register, cleared by reset.
      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign z_me     = z_me_int;
  assign z_mo     = z_mo_int;
  assign count_me = cnt_q[0];
  assign count_mo = cnt_q[1];
  assign state    = state_q;

endmodule

// File: tb/tb_run_detector_p.sv
// Directed bench for run_detector_p: four parameterisations share one stimulus.
module tb_run_detector_p;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic en    = 1'b1;
  logic clr   = 1'b0;
  logic w     = 1'b0;

  int checks = 0;
  int errors = 0;

  // Default: RUN_LEN=3, CNT_W=8, OVERLAP=1, SAT=1
  logic       z_me_ov, z_mo_ov;
  logic [7:0] cme_ov, cmo_ov;
  logic [1:0] st_ov;
  // OVERLAP=0
  logic       z_me_no, z_mo_no;
  logic [7:0] cme_no, cmo_no;
  logic [1:0] st_no;
  // CNT_W=2, SAT=1
  logic       z_me_sa, z_mo_sa;
  logic [1:0] cme_sa, cmo_sa;
  logic [1:0] st_sa;
  // CNT_W=2, SAT=0
  logic       z_me_wr, z_mo_wr;
  logic [1:0] cme_wr, cmo_wr;
  logic [1:0] st_wr;

  run_detector_p u_ov (
    .clock(clock), .reset(reset), .en(en), .clr(clr), .w(w),
    .z_me(z_me_ov), .z_mo(z_mo_ov), .count_me(cme_ov), .count_mo(cmo_ov), .state(st_ov)
  );
  run_detector_p #(.OVERLAP(0)) u_no (
    .clock(clock), .reset(reset), .en(en), .clr(clr), .w(w),
    .z_me(z_me_no), .z_mo(z_mo_no), .count_me(cme_no), .count_mo(cmo_no), .state(st_no)
  );
  run_detector_p #(.CNT_W(2), .SAT(1)) u_sa (
    .clock(clock), .reset(reset), .en(en), .clr(clr), .w(w),
    .z_me(z_me_sa), .z_mo(z_mo_sa), .count_me(cme_sa), .count_mo(cmo_sa), .state(st_sa)
  );
  run_detector_p #(.CNT_W(2), .SAT(0)) u_wr (
    .clock(clock), .reset(reset), .en(en), .clr(clr), .w(w),
    .z_me(z_me_wr), .z_mo(z_mo_wr), .count_me(cme_wr), .count_mo(cmo_wr), .state(st_wr)
  );

  always #5 clock = ~clock;

  // Drive one bit, wait one clock edge; inputs settle away from the edge.
  task automatic tick(input logic wv);
    w = wv;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    en = 1'b1; clr = 1'b1; w = 1'b1; reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0; clr = 1'b0; w = 1'b0;
    checks++;
    if (st_ov !== 2'd0 || cme_ov !== 8'd0 || cmo_ov !== 8'd0 || z_mo_ov !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d cme=%0d cmo=%0d z_mo=%b, want 0 0 0 0", st_ov, cme_ov, cmo_ov, z_mo_ov);
    end
    w = 1'b1; #1;
    checks++;
    if (z_me_ov !== 1'b0 || z_me_no !== 1'b0) begin
      errors++;
      $display("FAIL reset_zme: z_me ov=%b no=%b, want 0 0", z_me_ov, z_me_no);
    end
    w = 1'b0;
  endtask

  task automatic test_overlap;
    int wv [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int zs [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int st [8] = '{0, 1, 2, 3, 3, 3, 3, 0};
    test_reset();
    for (int i = 0; i < 8; i++) begin
      w = (wv[i] != 0);
      #1;
      checks++;
      if (z_me_ov !== (zs[i] != 0)) begin
        errors++;
        $display("FAIL overlap_zme[%0d]: got %b want %0d", i, z_me_ov, zs[i]);
      end
      @(posedge clock);
      #1;
      checks++;
      if (st_ov !== 2'(st[i]) || z_mo_ov !== (st[i] == 3)) begin
        errors++;
        $display("FAIL overlap_state[%0d]: state=%0d z_mo=%b want state=%0d", i, st_ov, z_mo_ov, st[i]);
      end
    end
    checks++;
    if (cme_ov !== 8'd4 || cmo_ov !== 8'd4) begin
      errors++;
      $display("FAIL overlap_counts: cme=%0d cmo=%0d want 4 4", cme_ov, cmo_ov);
    end
  endtask

  task automatic test_disjoint;
    int wv [7] = '{1, 1, 1, 1, 1, 1, 0};
    int zs [7] = '{0, 0, 1, 0, 0, 1, 0};
    int st [7] = '{1, 2, 3, 1, 2, 3, 0};
    test_reset();
    for (int i = 0; i < 7; i++) begin
      w = (wv[i] != 0);
      #1;
      checks++;
      if (z_me_no !== (zs[i] != 0)) begin
        errors++;
        $display("FAIL disjoint_zme[%0d]: got %b want %0d", i, z_me_no, zs[i]);
      end
      @(posedge clock);
      #1;
      checks++;
      if (st_no !== 2'(st[i])) begin
        errors++;
        $display("FAIL disjoint_state[%0d]: got %0d want %0d", i, st_no, st[i]);
      end
    end
    checks++;
    if (cme_no !== 8'd2 || cmo_no !== 8'd2) begin
      errors++;
      $display("FAIL disjoint_counts: cme=%0d cmo=%0d want 2 2", cme_no, cmo_no);
    end
  endtask

  task automatic test_broken_run;
    int wv [6] = '{1, 1, 0, 1, 1, 1};
    int zs [6] = '{0, 0, 0, 0, 0, 1};
    int st [6] = '{1, 2, 0, 1, 2, 3};
    test_reset();
    for (int i = 0; i < 6; i++) begin
      w = (wv[i] != 0);
      #1;
      checks++;
      if (z_me_ov !== (zs[i] != 0)) begin
        errors++;
        $display("FAIL broken_zme[%0d]: got %b want %0d", i, z_me_ov, zs[i]);
      end
      @(posedge clock);
      #1;
      checks++;
      if (st_ov !== 2'(st[i])) begin
        errors++;
        $display("FAIL broken_state[%0d]: got %0d want %0d", i, st_ov, st[i]);
      end
    end
    checks++;
    if (cme_ov !== 8'd1) begin
      errors++;
      $display("FAIL broken_count: cme=%0d want 1", cme_ov);
    end
  endtask

  task automatic test_saturate_wrap;
    test_reset();
    for (int i = 0; i < 8; i++) tick(1'b1);
    // Six Mealy hits and five Moore cycles into 2-bit counters.
    checks++;
    if (cme_sa !== 2'd3 || cmo_sa !== 2'd3) begin
      errors++;
      $display("FAIL sat_counts: cme=%0d cmo=%0d want 3 3", cme_sa, cmo_sa);
    end
    checks++;
    if (cme_wr !== 2'd2 || cmo_wr !== 2'd1) begin
      errors++;
      $display("FAIL wrap_counts: cme=%0d cmo=%0d want 2 1", cme_wr, cmo_wr);
    end
    checks++;
    if (cme_ov !== 8'd6 || cmo_ov !== 8'd5) begin
      errors++;
      $display("FAIL wide_counts: cme=%0d cmo=%0d want 6 5", cme_ov, cmo_ov);
    end
  endtask

  task automatic test_mid_run_controls;
    test_reset();
    tick(1'b1);
    tick(1'b1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = 1'b1;
      #1;
      checks++;
      if (z_me_ov !== 1'b0) begin
        errors++;
        $display("FAIL hold_zme[%0d]: got %b want 0", i, z_me_ov);
      end
      @(posedge clock);
      #1;
      checks++;
      if (st_ov !== 2'd2 || cmo_ov !== 8'd0) begin
        errors++;
        $display("FAIL hold_state[%0d]: state=%0d cmo=%0d want 2 0", i, st_ov, cmo_ov);
      end
    end
    en = 1'b1; w = 1'b1;
    #1;
    checks++;
    if (z_me_ov !== 1'b1) begin
      errors++;
      $display("FAIL resume_zme: got %b want 1", z_me_ov);
    end
    @(posedge clock);
    #1;
    checks++;
    if (st_ov !== 2'd3 || cme_ov !== 8'd1) begin
      errors++;
      $display("FAIL resume_state: state=%0d cme=%0d want 3 1", st_ov, cme_ov);
    end
    // Clear on a detecting edge: clear wins, state still advances.
    clr = 1'b1; w = 1'b1;
    #1;
    checks++;
    if (z_me_ov !== 1'b1) begin
      errors++;
      $display("FAIL clr_zme: got %b want 1", z_me_ov);
    end
    @(posedge clock);
    #1;
    clr = 1'b0;
    checks++;
    if (cme_ov !== 8'd0 || cmo_ov !== 8'd0 || st_ov !== 2'd3) begin
      errors++;
      $display("FAIL clr_counts: cme=%0d cmo=%0d state=%0d want 0 0 3", cme_ov, cmo_ov, st_ov);
    end
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    checks++;
    if (st_ov !== 2'd2 || cme_ov !== 8'd1 || cmo_ov !== 8'd2) begin
      errors++;
      $display("FAIL pre_reset: state=%0d cme=%0d cmo=%0d want 2 1 2", st_ov, cme_ov, cmo_ov);
    end
    reset = 1'b1; w = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (st_ov !== 2'd0 || cme_ov !== 8'd0 || cmo_ov !== 8'd0) begin
      errors++;
      $display("FAIL midrun_reset: state=%0d cme=%0d cmo=%0d want 0 0 0", st_ov, cme_ov, cmo_ov);
    end
    tick(1'b1);
    checks++;
    if (st_ov !== 2'd1) begin
      errors++;
      $display("FAIL restart: state=%0d want 1", st_ov);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_overlap();
    test_disjoint();
    test_broken_run();
    test_saturate_wrap();
    test_mid_run_controls();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
